// File: rtl/mul_dot_accumulator.sv
// Dot-product engine: registers 8-bit operand pairs, multiplies them and sums the
// products until the element flagged last, then presents the total with a valid/ready handshake.

module eight_bit_mul (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] mult
);
    // Unsigned shift-and-add multiplier, one partial product per multiplier bit.
    always_comb begin
        mult = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                mult = mult + (16'({8'b0, a}) << i);
            end
        end
    end
endmodule

module mul_dot_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    logic             s1_valid;
    logic [7:0]       s1_a;
    logic [7:0]       s1_b;
    logic             s1_last;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] run_cnt;
    logic             run_ovf;

    logic [15:0]      prod;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_next;
    logic             stall;
    logic             adv;
    logic             take_elem;
    logic             load_res;

    eight_bit_mul u_mul (
        .a    (s1_a),
        .b    (s1_b),
        .mult (prod)
    );

    // Only a last element can stall, and only while the previous result is still unread.
    assign stall     = s1_valid && s1_last && out_valid && !out_ready;
    assign adv       = !stall;
    assign in_ready  = adv;
    assign take_elem = adv && s1_valid;
    assign load_res  = take_elem && s1_last;

    assign sum      = {1'b0, acc} + (ACC_W+1)'(prod);
    assign cnt_next = (&run_cnt) ? run_cnt : run_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_last  <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid && in_ready;
            if (in_valid) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_last <= in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            run_cnt <= '0;
            run_ovf <= 1'b0;
        end else if (take_elem) begin
            if (s1_last) begin
                acc     <= '0;
                run_cnt <= '0;
                run_ovf <= 1'b0;
            end else begin
                acc     <= sum[ACC_W-1:0];
                run_cnt <= cnt_next;
                run_ovf <= run_ovf | sum[ACC_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            acc_out   <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else if (load_res) begin
            out_valid <= 1'b1;
            acc_out   <= sum[ACC_W-1:0];
            count     <= cnt_next;
            overflow  <= run_ovf | sum[ACC_W];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mul_dot_accumulator.sv
// Directed bench for mul_dot_accumulator: a default instance plus a narrow
// (16-bit accumulator, 2-bit count) instance sharing the same stimulus.

module tb_mul_dot_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [23:0] acc_out;
    logic [7:0]  count;
    logic        overflow;

    logic        in_ready16;
    logic        out_valid16;
    logic [15:0] acc_out16;
    logic [1:0]  count16;
    logic        overflow16;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mul_dot_accumulator #(.ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .acc_out(acc_out), .count(count), .overflow(overflow)
    );

    mul_dot_accumulator #(.ACC_W(16), .CNT_W(2)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .in_last(in_last), .out_valid(out_valid16),
        .out_ready(out_ready), .acc_out(acc_out16), .count(count16), .overflow(overflow16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic l);
        in_valid = v;
        a        = x;
        b        = y;
        in_last  = l;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_acc_out", 32'(acc_out), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid16", 32'(out_valid16), 32'd0);

        // Single element vector, 0xAA*0xF0
        drive(1'b1, 8'hAA, 8'hF0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("single_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_acc", 32'(acc_out), 32'h9F60);
        chk("single_count", 32'(count), 32'd1);
        chk("single_ovf", 32'(overflow), 32'd0);
        tick();
        chk("single_valid_drop", 32'(out_valid), 32'd0);

        // Four elements 0xFF*0xFF; narrow instance wraps and saturates its count at 3
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hFF, 8'hFF, (i == 3));
            #1;
            chk("four_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("four_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("four_valid", 32'(out_valid), 32'd1);
        chk("four_acc", 32'(acc_out), 32'h03F804);
        chk("four_count", 32'(count), 32'd4);
        chk("four_ovf", 32'(overflow), 32'd0);
        chk("four_acc16", 32'(acc_out16), 32'hF804);
        chk("four_ovf16", 32'(overflow16), 32'd1);
        chk("four_count16_sat", 32'(count16), 32'd3);
        tick();
        chk("four_valid_drop", 32'(out_valid), 32'd0);

        // Two 0xFF*0xFF then a fresh vector 2*3
        drive(1'b1, 8'hFF, 8'hFF, 1'b0);
        tick();
        drive(1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        drive(1'b1, 8'h02, 8'h03, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("two_acc16", 32'(acc_out16), 32'hFC02);
        chk("two_ovf16", 32'(overflow16), 32'd1);
        chk("two_count16", 32'(count16), 32'd2);
        chk("two_acc24", 32'(acc_out), 32'h01FC02);
        chk("two_ovf24", 32'(overflow), 32'd0);
        tick();
        chk("next_valid16", 32'(out_valid16), 32'd1);
        chk("next_acc16", 32'(acc_out16), 32'd6);
        chk("next_ovf16", 32'(overflow16), 32'd0);
        chk("next_count16", 32'(count16), 32'd1);
        tick();
        chk("next_valid_drop", 32'(out_valid), 32'd0);

        // Backpressure: {1*1},{2*2},{3*3} with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 8'd1, 8'd1, 1'b1);
        tick();
        drive(1'b1, 8'd2, 8'd2, 1'b1);
        #1;
        chk("bp_ready_first", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 8'd3, 8'd3, 1'b1);
        #1;
        chk("bp_valid1", 32'(out_valid), 32'd1);
        chk("bp_acc1", 32'(acc_out), 32'd1);
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bp_hold_acc", 32'(acc_out), 32'd1);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("bp_valid2", 32'(out_valid), 32'd1);
        chk("bp_acc2", 32'(acc_out), 32'd4);
        chk("bp_count2", 32'(count), 32'd1);
        tick();
        chk("bp_valid3", 32'(out_valid), 32'd1);
        chk("bp_acc3", 32'(acc_out), 32'd9);
        tick();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // Reset mid-vector, also with a result pending
        out_ready = 1'b0;
        drive(1'b1, 8'd7, 8'd7, 1'b1);
        tick();
        drive(1'b1, 8'd10, 8'd10, 1'b0);
        tick();
        drive(1'b1, 8'd20, 8'd20, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("mid_pending", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_acc", 32'(acc_out), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 8'd3, 8'd5, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("mid_after_valid", 32'(out_valid), 32'd1);
        chk("mid_after_acc", 32'(acc_out), 32'd15);
        chk("mid_after_count", 32'(count), 32'd1);
        tick();

        // Streaming single-element vectors a=i, b=i+1
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 8'(i + 1), 1'b1);
            tick();
            if (i >= 1) begin
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_acc", 32'(acc_out), 32'((i - 1) * i));
            end
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("stream_last_valid", 32'(out_valid), 32'd1);
        chk("stream_last_acc", 32'(acc_out), 32'd56);
        tick();
        chk("stream_drain", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end
endmodule
